hs_pipe_buffer: RTL and testbench

- Clocked, parametrised successor of the single req/ack pipeline stage: DEPTH-entry elastic buffer with four-phase req/ack handshakes on both sides.
- Upstream pushes tokens via req_in/ack_out. Downstream pops tokens via req_out/ack_in.
- Used to chain asynchronous-style stages inside one synchronous clock domain, with buffering and explicit full/empty back-pressure.

---
 rtl/hs_pipe_buffer.sv | 132 +++++++++++++
 tb/tb_hs_pipe_buffer.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hs_pipe_buffer.sv
// DEPTH-entry elastic buffer with four-phase req/ack handshakes on both sides.
// Optional macro HS_PIPE_BUFFER_LEVEL_EN exposes occupancy (level) and full flags.
module hs_pipe_buffer #(
    parameter int DATA_W = 3,
    parameter int DEPTH  = 4,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_in,
    input  logic [DATA_W-1:0] data_in,
    output logic              ack_out,
    output logic              req_out,
    output logic [DATA_W-1:0] data_out,
    input  logic              ack_in
`ifdef HS_PIPE_BUFFER_LEVEL_EN
    ,
    output logic [CNT_W-1:0]  level,
    output logic              full
`endif
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] LAST_SLOT = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(DEPTH);

    typedef enum logic [1:0] {IN_SYNC, IN_IDLE, IN_ACK} in_state_t;
    typedef enum logic [1:0] {OUT_IDLE, OUT_REQ, OUT_RTZ} out_state_t;

    in_state_t         in_state_reg, in_state_next;
    out_state_t        out_state_reg, out_state_next;
    logic              ack_reg, ack_next;
    logic              req_reg, req_next;
    logic [DATA_W-1:0] data_reg;
    logic [CNT_W-1:0]  count_reg;
    logic [PTR_W-1:0]  wptr_reg, rptr_reg;
    logic [DATA_W-1:0] mem [DEPTH];
    logic              push, pop, load;

    // Full is judged on the pre-edge count, so a same-cycle pop never frees a slot early.
    always_comb begin
        in_state_next = in_state_reg;
        ack_next      = 1'b0;
        push          = 1'b0;
        case (in_state_reg)
            IN_SYNC: begin
                if (!req_in) in_state_next = IN_IDLE;
            end
            IN_IDLE: begin
                if (req_in && (count_reg < FULL_CNT)) begin
                    push          = 1'b1;
                    ack_next      = 1'b1;
                    in_state_next = IN_ACK;
                end
            end
            IN_ACK: begin
                if (req_in) ack_next = 1'b1;
                else        in_state_next = IN_IDLE;
            end
            default: in_state_next = IN_SYNC;
        endcase
    end

    always_comb begin
        out_state_next = out_state_reg;
        req_next       = 1'b0;
        pop            = 1'b0;
        load           = 1'b0;
        case (out_state_reg)
            OUT_IDLE: begin
                if ((count_reg != '0) && !ack_in) begin
                    load           = 1'b1;
                    req_next       = 1'b1;
                    out_state_next = OUT_REQ;
                end
            end
            OUT_REQ: begin
                if (ack_in) begin
                    pop            = 1'b1;
                    out_state_next = OUT_RTZ;
                end else begin
                    req_next = 1'b1;
                end
            end
            OUT_RTZ: begin
                if (!ack_in) out_state_next = OUT_IDLE;
            end
            default: out_state_next = OUT_RTZ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            in_state_reg  <= IN_SYNC;
            out_state_reg <= OUT_RTZ;
            ack_reg       <= 1'b0;
            req_reg       <= 1'b0;
            data_reg      <= '0;
            count_reg     <= '0;
            wptr_reg      <= '0;
            rptr_reg      <= '0;
        end else begin
            in_state_reg  <= in_state_next;
            out_state_reg <= out_state_next;
            ack_reg       <= ack_next;
            req_reg       <= req_next;
            if (load) data_reg <= mem[rptr_reg];
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
            if (push) wptr_reg <= (wptr_reg == LAST_SLOT) ? '0 : wptr_reg + 1'b1;
            if (pop)  rptr_reg <= (rptr_reg == LAST_SLOT) ? '0 : rptr_reg + 1'b1;
        end
    end

    // Storage carries no reset; a write racing reset is orphaned by the pointer reset.
    always_ff @(posedge clk) begin
        if (push) mem[wptr_reg] <= data_in;
    end

    assign ack_out  = ack_reg;
    assign req_out  = req_reg;
    assign data_out = data_reg;

`ifdef HS_PIPE_BUFFER_LEVEL_EN
    assign level = count_reg;
    assign full  = (count_reg == FULL_CNT);
`endif

endmodule

// File: tb/tb_hs_pipe_buffer.sv
// Self-checking bench for hs_pipe_buffer: queue-based reference model checked every cycle,
// plus directed handshake scenarios and randomized streams.
module tb_hs_pipe_buffer;

    localparam int DATA_W = 3;
    localparam int DEPTH  = 4;
    localparam int CNT_W  = $clog2(DEPTH + 1);

    logic              clk = 1'b0;
    logic              rst;
    logic              req_in;
    logic [DATA_W-1:0] data_in;
    logic              ack_out;
    logic              req_out;
    logic [DATA_W-1:0] data_out;
    logic              ack_in;
`ifdef HS_PIPE_BUFFER_LEVEL_EN
    logic [CNT_W-1:0]  level;
    logic              full;
`endif

    hs_pipe_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .req_in   (req_in),
        .data_in  (data_in),
        .ack_out  (ack_out),
        .req_out  (req_out),
        .data_out (data_out),
        .ack_in   (ack_in)
`ifdef HS_PIPE_BUFFER_LEVEL_EN
        ,
        .level    (level),
        .full     (full)
`endif
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: buffer contents as a queue, handshake phases as flags.
    logic [DATA_W-1:0] m_q[$];
    logic [DATA_W-1:0] m_dout;
    bit m_ack, m_req, m_sync, m_rtz, m_valid;
    bit m_push, m_pop, m_load;

    initial begin
        m_valid = 0;
        forever begin
            @(posedge clk);
            if (rst) begin
                m_q.delete();
                m_ack = 0; m_req = 0; m_dout = '0;
                m_sync = 1; m_rtz = 1; m_valid = 1;
            end else if (m_valid) begin
                m_push = !m_sync && !m_ack && req_in && (m_q.size() < DEPTH);
                m_pop  = m_req && ack_in;
                m_load = !m_req && !m_rtz && (m_q.size() > 0) && !ack_in;
                if (m_load) m_dout = m_q[0];
                if (m_pop)  void'(m_q.pop_front());
                if (m_push) m_q.push_back(data_in);
                if (m_sync) begin
                    if (!req_in) m_sync = 0;
                end else if (m_ack) begin
                    if (!req_in) m_ack = 0;
                end else if (m_push) begin
                    m_ack = 1;
                end
                if (m_pop) begin
                    m_req = 0; m_rtz = 1;
                end else if (m_rtz) begin
                    if (!ack_in) m_rtz = 0;
                end else if (m_load) begin
                    m_req = 1;
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (m_valid) begin
                chk("ack_out", ack_out, m_ack);
                chk("req_out", req_out, m_req);
                chk("data_out", data_out, m_dout);
`ifdef HS_PIPE_BUFFER_LEVEL_EN
                chk("level", level, m_q.size());
                chk("full", full, (m_q.size() == DEPTH));
`endif
            end
        end
    end

    // Record every token that completes a downstream handshake.
    logic [DATA_W-1:0] out_log[$];
    logic [DATA_W-1:0] exp_q[$];

    initial begin
        forever begin
            @(negedge clk);
            if (!rst && req_out && ack_in) out_log.push_back(data_out);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_token(logic [DATA_W-1:0] v);
        bit got = 0;
        req_in  = 1'b1;
        data_in = v;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (ack_out) begin
                got = 1;
                break;
            end
        end
        chk("push_ack", got, 1);
        req_in = 1'b0;
        tick();
        if (got) exp_q.push_back(v);
    endtask

    task automatic drain(int n);
        bit done = 0;
        for (int c = 0; c < 300; c++) begin
            if (ack_in && !req_out)      ack_in = 1'b0;
            else if (!ack_in && req_out) ack_in = 1'b1;
            tick();
            if (out_log.size() >= n && !ack_in) begin
                done = 1;
                break;
            end
        end
        chk("drain_done", done, 1);
    endtask

    task automatic compare_log(string tag);
        chk({tag, "_count"}, out_log.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < out_log.size(); i++)
            chk({tag, "_order"}, out_log[i], exp_q[i]);
    endtask

    // Both sides follow the four-phase protocol with random willingness per cycle.
    task automatic run_stream(int up_pct, int dn_pct);
        int idx  = 0;
        int n    = exp_q.size();
        bit done = 0;
        out_log.delete();
        for (int c = 0; c < n * 40 + 100; c++) begin
            if (req_in && ack_out) begin
                req_in = 1'b0;
                idx++;
            end else if (!req_in && !ack_out && idx < n && $urandom_range(99) < up_pct) begin
                req_in  = 1'b1;
                data_in = exp_q[idx];
            end
            if (ack_in && !req_out)
                ack_in = 1'b0;
            else if (!ack_in && req_out && $urandom_range(99) < dn_pct)
                ack_in = 1'b1;
            tick();
            if (idx == n && !req_in && out_log.size() == n && !ack_in) begin
                done = 1;
                break;
            end
        end
        chk("stream_done", done, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; req_in = 1'b1; ack_in = 1'b0; data_in = 3'd2;
        tick();
        tick();
        chk("rst_ack_out", ack_out, 0);
        chk("rst_req_out", req_out, 0);
        chk("rst_data_out", data_out, 0);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("sync_no_ack", ack_out, 0);
        end
        req_in = 1'b0;
        tick();
        exp_q.delete(); out_log.delete();

        // Single token latency
        req_in = 1'b1; data_in = 3'd1;
        tick();
        chk("accept_latency", ack_out, 1);
        chk("not_presented_yet", req_out, 0);
        req_in = 1'b0;
        tick();
        chk("present_latency", req_out, 1);
        chk("present_data", data_out, 1);
        chk("ack_rtz", ack_out, 0);
        ack_in = 1'b1;
        tick();
        chk("pop_req_low", req_out, 0);
        ack_in = 1'b0;
        tick();
        chk("single_empty", m_q.size(), 0);
        exp_q.push_back(3'd1);
        compare_log("single");

        // Fill and stall
        exp_q.delete(); out_log.delete();
        for (int v = 1; v <= 4; v++) push_token(v[DATA_W-1:0]);
        chk("fill_req", req_out, 1);
        chk("fill_head", data_out, 1);
        chk("fill_count", m_q.size(), 4);
        req_in = 1'b1; data_in = 3'd5;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("full_no_ack", ack_out, 0);
        end
        ack_in = 1'b1;
        tick();
        chk("full_same_edge_no_ack", ack_out, 0);
        chk("full_pop_req_low", req_out, 0);
        ack_in = 1'b0;
        tick();
        chk("ack_after_pop", ack_out, 1);
        req_in = 1'b0;
        tick();
        exp_q.push_back(3'd5);
        drain(5);
        compare_log("fill");

        // Simultaneous push and pop at count 2
        exp_q.delete(); out_log.delete();
        push_token(3'd6);
        push_token(3'd7);
        chk("simul_pre_count", m_q.size(), 2);
        req_in = 1'b1; data_in = 3'd3; ack_in = 1'b1;
        tick();
        chk("simul_ack", ack_out, 1);
        chk("simul_req_low", req_out, 0);
        chk("simul_count", m_q.size(), 2);
        req_in = 1'b0; ack_in = 1'b0;
        tick();
        exp_q.push_back(3'd3);
        drain(3);
        compare_log("simul");

        // Reset with tokens buffered and a request pending downstream
        exp_q.delete(); out_log.delete();
        push_token(3'd1);
        push_token(3'd2);
        push_token(3'd3);
        chk("mid_req", req_out, 1);
        rst = 1'b1;
        tick();
        chk("mid_rst_req", req_out, 0);
        chk("mid_rst_data", data_out, 0);
        chk("mid_rst_ack", ack_out, 0);
        rst = 1'b0;
        exp_q.delete(); out_log.delete();
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("no_stale_token", req_out, 0);
        end
        push_token(3'd5);
        drain(1);
        compare_log("after_rst");

        // Wrap-around with an immediate-ack downstream
        exp_q.delete();
        for (int v = 0; v < 10; v++) exp_q.push_back(v[DATA_W-1:0]);
        run_stream(100, 100);
        compare_log("wrap");

        // Randomized streams: balanced, then slow consumer to exercise full
        exp_q.delete();
        for (int i = 0; i < 150; i++) exp_q.push_back(DATA_W'($urandom_range(7)));
        run_stream(60, 60);
        compare_log("rand_bal");
        exp_q.delete();
        for (int i = 0; i < 100; i++) exp_q.push_back(DATA_W'($urandom_range(7)));
        run_stream(90, 25);
        compare_log("rand_slow");

        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
